// File: rtl/return_addr_stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ras_pkg
//  Brief    : Shared defaults, types and op encoding for the return-address
//             stack.
//  Revision : 1.0 - initial release
// ============================================================================
package ras_pkg;

    localparam int RAS_DEPTH  = 8;
    localparam int RAS_ADDR_W = 12;

    typedef logic [RAS_ADDR_W-1:0] ras_addr_t;

    // Encoded directly as {push, pop} so the decode is a plain cast.
    typedef enum logic [1:0] {
        RAS_NOP     = 2'b00,
        RAS_POP     = 2'b01,
        RAS_PUSH    = 2'b10,
        RAS_REPLACE = 2'b11
    } ras_op_e;

endpackage
`default_nettype wire

// File: rtl/return_addr_stack_if.sv
`default_nettype none
// ============================================================================
//  Module   : return_addr_stack_if
//  Brief    : Request/status bundle between the EX stage and the
//             return-address stack.
//  Revision : 1.0 - initial release
// ============================================================================
interface return_addr_stack_if
    import ras_pkg::*;
#(
    parameter int DEPTH  = RAS_DEPTH,
    parameter int ADDR_W = RAS_ADDR_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              push;
    logic              pop;
    logic              flush;
    logic [ADDR_W-1:0] push_addr;
    logic              clr_err;
    logic [ADDR_W-1:0] top_addr;
    logic              empty;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, pop, flush, push_addr, clr_err,
        input  top_addr, empty, full, count, overflow, underflow
    );

    modport slave (
        input  push, pop, flush, push_addr, clr_err,
        output top_addr, empty, full, count, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/return_addr_stack_storage.sv
`default_nettype none
// ============================================================================
//  Module   : ras_storage
//  Brief    : DEPTH x ADDR_W register array, one write port, one async read
//             port. Contents are not reset.
//  Revision : 1.0 - initial release
// ============================================================================
module ras_storage #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              we,
    input  wire logic [IDX_W-1:0]  waddr,
    input  wire logic [ADDR_W-1:0] wdata,
    input  wire logic [IDX_W-1:0]  raddr,
    output logic      [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] r_mem [DEPTH];

    // Single write port; no reset so the array maps onto plain flops/LUTRAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
//  Module   : return_addr_stack
//  Brief    : Return-address stack driven by the ID/EX push/pop control bits.
//             Presents the top entry to the PC-source mux, tracks occupancy
//             and keeps sticky overflow/underflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module return_addr_stack
    import ras_pkg::*;
#(
    parameter int DEPTH  = RAS_DEPTH,
    parameter int ADDR_W = RAS_ADDR_W
) (
    input wire logic           clk,
    input wire logic           rst,
    return_addr_stack_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);

    logic [CNT_W-1:0]  r_sp;
    logic [CNT_W-1:0]  w_sp_nx;
    logic              r_ovf;
    logic              r_unf;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_p;
    logic              w_q;
    logic              w_empty;
    logic              w_full;
    logic              w_we;
    logic [IDX_W-1:0]  w_waddr;
    logic [IDX_W-1:0]  w_top_idx;
    logic [ADDR_W-1:0] w_rdata;
    ras_op_e           w_op;

    // A flushed EX slot contributes no request at all.
    assign w_p     = bus.push & ~bus.flush;
    assign w_q     = bus.pop  & ~bus.flush;
    assign w_op    = ras_op_e'({w_p, w_q});
    assign w_empty = (r_sp == '0);
    assign w_full  = (r_sp == C_DEPTH);

    // Index of the current top; only meaningful when not empty.
    assign w_top_idx = IDX_W'(r_sp - C_ONE);

    // Decode the operation into a storage write, next pointer and error events.
    always_comb begin
        w_we      = 1'b0;
        w_waddr   = w_top_idx;
        w_sp_nx   = r_sp;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        case (w_op)
            RAS_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we    = 1'b1;
                    w_waddr = IDX_W'(r_sp);
                    w_sp_nx = r_sp + C_ONE;
                end
            end
            RAS_POP: begin
                if (w_empty) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_sp_nx = r_sp - C_ONE;
                end
            end
            RAS_REPLACE: begin
                w_we = 1'b1;
                if (w_empty) begin
                    // Pop half fails, push half still lands in slot 0.
                    w_unf_set = 1'b1;
                    w_waddr   = '0;
                    w_sp_nx   = C_ONE;
                end
            end
            default: begin
            end
        endcase
    end

    // Pointer and sticky flags; an error event beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_sp  <= w_sp_nx;
            r_ovf <= (r_ovf & ~bus.clr_err) | w_ovf_set;
            r_unf <= (r_unf & ~bus.clr_err) | w_unf_set;
        end
    end

    ras_storage #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W)
    ) u_storage (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (bus.push_addr),
        .raddr (w_top_idx),
        .rdata (w_rdata)
    );

    assign bus.top_addr  = w_empty ? '0 : w_rdata;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_sp;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_return_addr_stack.sv
`default_nettype none
// ============================================================================
//  Module   : tb_return_addr_stack
//  Brief    : Directed, table-driven bench for return_addr_stack.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_return_addr_stack;
    import ras_pkg::*;

    typedef struct {
        string     name;
        logic      push;
        logic      pop;
        logic      flush;
        logic      clr;
        ras_addr_t addr;
        int        ecnt;
        ras_addr_t etop;
        logic      eovf;
        logic      eunf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    vec_t vecs[$];

    return_addr_stack_if #(.DEPTH(8), .ADDR_W(12)) bus ();

    return_addr_stack #(.DEPTH(8), .ADDR_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string name, input logic push, input logic pop,
                       input logic flush, input logic clr, input ras_addr_t addr,
                       input int ecnt, input ras_addr_t etop,
                       input logic eovf, input logic eunf);
        vec_t v;
        v.name = name; v.push = push; v.pop = pop; v.flush = flush; v.clr = clr;
        v.addr = addr; v.ecnt = ecnt; v.etop = etop; v.eovf = eovf; v.eunf = eunf;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic push, input logic pop, input logic flush,
                         input logic clr, input ras_addr_t addr);
        bus.push      = push;
        bus.pop       = pop;
        bus.flush     = flush;
        bus.clr_err   = clr;
        bus.push_addr = addr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int ecnt, input ras_addr_t etop,
                         input logic eovf, input logic eunf);
        logic [3:0] exp_cnt;
        logic       exp_empty;
        logic       exp_full;
        exp_cnt   = 4'(ecnt);
        exp_empty = (ecnt == 0);
        exp_full  = (ecnt == 8);
        n_total++;
        if (bus.count !== exp_cnt || bus.top_addr !== etop || bus.empty !== exp_empty ||
            bus.full !== exp_full || bus.overflow !== eovf || bus.underflow !== eunf) begin
            $display("FAIL %s: got cnt=%0d top=%h e=%b f=%b ovf=%b unf=%b, want cnt=%0d top=%h e=%b f=%b ovf=%b unf=%b",
                     name, bus.count, bus.top_addr, bus.empty, bus.full, bus.overflow,
                     bus.underflow, exp_cnt, etop, exp_empty, exp_full, eovf, eunf);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);

        // Vector table: inputs for one cycle, then state expected after the edge.
        add("idle",        0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0);
        add("pop_empty",   0, 1, 0, 0, 12'h000, 0, 12'h000, 0, 1);
        add("clr_unf",     0, 0, 0, 1, 12'h000, 0, 12'h000, 0, 0);
        add("push_010",    1, 0, 0, 0, 12'h010, 1, 12'h010, 0, 0);
        add("push_020",    1, 0, 0, 0, 12'h020, 2, 12'h020, 0, 0);
        add("push_030",    1, 0, 0, 0, 12'h030, 3, 12'h030, 0, 0);
        add("pop_a",       0, 1, 0, 0, 12'h000, 2, 12'h020, 0, 0);
        add("pop_b",       0, 1, 0, 0, 12'h000, 1, 12'h010, 0, 0);
        add("pop_c",       0, 1, 0, 0, 12'h000, 0, 12'h000, 0, 0);
        for (int i = 0; i < 8; i++)
            add($sformatf("fill_%0d", i), 1, 0, 0, 0, ras_addr_t'(12'h100 + i),
                i + 1, ras_addr_t'(12'h100 + i), 0, 0);
        add("push_full",   1, 0, 0, 0, 12'h1FF, 8, 12'h107, 1, 0);
        add("clr_ovf",     0, 0, 0, 1, 12'h000, 8, 12'h107, 0, 0);
        add("repl_full",   1, 1, 0, 0, 12'h1AB, 8, 12'h1AB, 0, 0);
        for (int j = 7; j >= 0; j--)
            add($sformatf("drain_%0d", j), 0, 1, 0, 0, 12'h000, j,
                (j == 0) ? 12'h000 : ras_addr_t'(12'h100 + j - 1), 0, 0);
        add("push_033",    1, 0, 0, 0, 12'h033, 1, 12'h033, 0, 0);
        add("push_055",    1, 0, 0, 0, 12'h055, 2, 12'h055, 0, 0);
        add("repl_0AA",    1, 1, 0, 0, 12'h0AA, 2, 12'h0AA, 0, 0);
        add("pop_after_r", 0, 1, 0, 0, 12'h000, 1, 12'h033, 0, 0);
        add("pop_to_zero", 0, 1, 0, 0, 12'h000, 0, 12'h000, 0, 0);
        add("repl_empty",  1, 1, 0, 0, 12'h0BB, 1, 12'h0BB, 0, 1);
        add("clr_unf2",    0, 0, 0, 1, 12'h000, 1, 12'h0BB, 0, 0);
        add("flush_push",  1, 0, 1, 0, 12'h123, 1, 12'h0BB, 0, 0);
        add("flush_pop",   0, 1, 1, 0, 12'h000, 1, 12'h0BB, 0, 0);
        add("pop_last",    0, 1, 0, 0, 12'h000, 0, 12'h000, 0, 0);
        add("unf_vs_clr",  0, 1, 0, 1, 12'h000, 0, 12'h000, 0, 1);

        // Asynchronous reset must take effect before any clock edge.
        #2;
        check("reset_state", 0, 12'h000, 0, 0);
        step();
        rst = 1'b0;

        foreach (vecs[k]) begin
            drive(vecs[k].push, vecs[k].pop, vecs[k].flush, vecs[k].clr, vecs[k].addr);
            step();
            check(vecs[k].name, vecs[k].ecnt, vecs[k].etop, vecs[k].eovf, vecs[k].eunf);
        end

        // Mid-operation async reset between edges, then normal operation resumes.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h044);
            step();
        end
        check("pre_reset", 3, 12'h044, 0, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", 0, 12'h000, 0, 0);
        #1;
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 12'h001);
        step();
        check("post_reset_push", 1, 12'h001, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
